// File: rtl/systolic_ctrl.sv
// Sequencing controller for a SIZE x SIZE systolic MAC array.
// Clears the array, streams one column of A and one row of B per cycle from the operand
// buffers, skews each lane by its index with zero padding, then waits for the wavefront
// to drain before flagging the result as valid.
module systolic_ctrl #(
    parameter int unsigned SIZE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     result_valid,
    output logic                     rd_en,
    output logic [$clog2(SIZE)-1:0]  rd_addr,
    input  logic [8*SIZE-1:0]        a_col,
    input  logic [8*SIZE-1:0]        b_row,
    output logic                     arr_reset,
    output logic                     load_en,
    output logic                     mult_en,
    output logic                     acc_en,
    output logic [8*SIZE-1:0]        a_in,
    output logic [8*SIZE-1:0]        b_in
);

    localparam int unsigned AW = $clog2(SIZE);
    // Counter must reach 2*SIZE-1 for the drain phase.
    localparam int unsigned CW = $clog2(2 * SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StDone
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            rv_q;
    logic            rd_en_q;
    logic [AW-1:0]   rd_addr_q;
    logic            en_q;
    logic            vld_q;

    // Main sequencer: state, phase counter and all registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            en_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        rv_q    <= 1'b0;
                    end
                end
                StClear: begin
                    state_q   <= StFeed;
                    cnt_q     <= '0;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                    en_q      <= 1'b1;
                end
                StFeed: begin
                    if (cnt_q == CW'(SIZE - 1)) begin
                        state_q   <= StDrain;
                        cnt_q     <= '0;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                    end else begin
                        cnt_q     <= cnt_q + CW'(1);
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                StDrain: begin
                    if (cnt_q == CW'(2 * SIZE - 1)) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        rv_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    // A start seen here is dropped, not queued.
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Buffer read latency: operands on a_col/b_row are valid one cycle after rd_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= rd_en_q;
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign a_in[7:0] = vld_q ? a_col[7:0] : 8'd0;
            assign b_in[7:0] = vld_q ? b_row[7:0] : 8'd0;
        end else begin : g_skew
            logic [7:0]   a_sr [i];
            logic [7:0]   b_sr [i];
            logic [i-1:0] v_sr;

            // Lane i delays data and valid by i cycles so the wavefront lines up diagonally.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr[s] <= 8'd0;
                        b_sr[s] <= 8'd0;
                    end
                    v_sr <= '0;
                end else begin
                    a_sr[0] <= a_col[8*i +: 8];
                    b_sr[0] <= b_row[8*i +: 8];
                    v_sr[0] <= vld_q;
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                        v_sr[s] <= v_sr[s-1];
                    end
                end
            end

            // Zero padding keeps accumulation harmless while enables stay high.
            assign a_in[8*i +: 8] = v_sr[i-1] ? a_sr[i-1] : 8'd0;
            assign b_in[8*i +: 8] = v_sr[i-1] ? b_sr[i-1] : 8'd0;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign load_en      = en_q;
    assign mult_en      = en_q;
    assign acc_en       = en_q;
    assign arr_reset    = reset | (state_q == StClear);

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: a timeline model keyed on cycles since
// acceptance, an operand-buffer model, and a behavioural systolic array consuming a_in/b_in.
module tb_systolic_ctrl;

    localparam int unsigned SIZE = 4;
    localparam int unsigned AW   = $clog2(SIZE);
    localparam int          LAST = 3 * SIZE + 2;

    logic                clk;
    logic                reset;
    logic                start;
    logic                busy;
    logic                done;
    logic                result_valid;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [8*SIZE-1:0]   a_col;
    logic [8*SIZE-1:0]   b_row;
    logic                arr_reset;
    logic                load_en;
    logic                mult_en;
    logic                acc_en;
    logic [8*SIZE-1:0]   a_in;
    logic [8*SIZE-1:0]   b_in;

    systolic_ctrl #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .a_col        (a_col),
        .b_row        (b_row),
        .arr_reset    (arr_reset),
        .load_en      (load_en),
        .mult_en      (mult_en),
        .acc_en       (acc_en),
        .a_in         (a_in),
        .b_in         (b_in)
    );

    int checks = 0;
    int errors = 0;

    int unsigned mat_a [SIZE][SIZE];
    int unsigned mat_b [SIZE][SIZE];

    // Cycles since the accepting edge (0 = no job in flight).
    int  age      = 0;
    bit  rv_m     = 1'b0;
    int  done_cnt = 0;
    int  clr_cnt  = 0;
    bit  skew_tag = 1'b0;

    longint      acc [SIZE][SIZE];
    int unsigned ah  [SIZE][SIZE];
    int unsigned bv  [SIZE][SIZE];

    bit rd_en_s   = 1'b0;
    int rd_addr_s = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lane(input logic [8*SIZE-1:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operand buffers: return A[*][k] / B[k][*] one cycle after a read, garbage otherwise.
    initial begin
        a_col = '0;
        b_row = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < SIZE; i++) begin
                if (rd_en_s) begin
                    a_col[8*i +: 8] = 8'(mat_a[i][rd_addr_s]);
                    b_row[8*i +: 8] = 8'(mat_b[rd_addr_s][i]);
                end else begin
                    a_col[8*i +: 8] = 8'($urandom);
                    b_row[8*i +: 8] = 8'($urandom);
                end
            end
        end
    end

    // Per-cycle compare against the timeline model, then advance the models.
    initial begin
        int          d;
        bit          in_feed;
        bit          in_run;
        int unsigned exp_v;
        int unsigned a_at;
        int unsigned b_at;
        forever begin
            @(negedge clk);
            d       = age;
            in_feed = (d >= 2) && (d <= SIZE + 1);
            in_run  = (d >= 2) && (d <= LAST - 1);
            check("busy", busy, (d >= 1) && (d <= LAST));
            check("done", done, d == LAST);
            check("rd_en", rd_en, in_feed);
            check("rd_addr", rd_addr, in_feed ? d - 2 : 0);
            check("arr_reset", arr_reset, reset || (d == 1));
            check("load_en", load_en, in_run);
            check("mult_en", mult_en, in_run);
            check("acc_en", acc_en, in_run);
            check("result_valid", result_valid, rv_m);
            for (int i = 0; i < SIZE; i++) begin
                exp_v = 0;
                if (d >= 3 + i && d <= 2 + i + int'(SIZE)) exp_v = mat_a[i][d-3-i];
                check($sformatf("a_in[%0d]", i), lane(a_in, i), exp_v);
                exp_v = 0;
                if (d >= 3 + i && d <= 2 + i + int'(SIZE)) exp_v = mat_b[d-3-i][i];
                check($sformatf("b_in[%0d]", i), lane(b_in, i), exp_v);
            end
            if (skew_tag && d >= 1 && d <= LAST) begin
                exp_v = (d >= 6 && d <= 9) ? 49 + d - 6 : 0;
                check("skew_a3", lane(a_in, 3), exp_v);
                check("skew_b3", lane(b_in, 3), exp_v);
            end
            if (done === 1'b1) begin
                done_cnt++;
                check("done_age", d, 14);
            end
            if (arr_reset === 1'b1 && !reset) clr_cnt++;
            rd_en_s   = rd_en;
            rd_addr_s = int'(rd_addr);

            // Array: A flows east, B flows south, each PE multiplies what passes it.
            if (arr_reset) begin
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        acc[i][j] = 0;
                        ah[i][j]  = 0;
                        bv[i][j]  = 0;
                    end
                end
            end else if (load_en) begin
                for (int i = SIZE - 1; i >= 0; i--) begin
                    for (int j = SIZE - 1; j >= 0; j--) begin
                        if (j == 0) a_at = lane(a_in, i);
                        else        a_at = ah[i][j-1];
                        if (i == 0) b_at = lane(b_in, j);
                        else        b_at = bv[i-1][j];
                        acc[i][j] = acc[i][j] + longint'(a_at) * longint'(b_at);
                        ah[i][j]  = a_at;
                        bv[i][j]  = b_at;
                    end
                end
            end

            if (reset) begin
                age  = 0;
                rv_m = 1'b0;
            end else if (age == 0) begin
                if (start) begin
                    age  = 1;
                    rv_m = 1'b0;
                end
            end else if (age == LAST) begin
                age = 0;
            end else begin
                age++;
                if (age == LAST) rv_m = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_job();
        int n;
        start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 4);
        start = 1'b0;
        check("accept", busy, 1);
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check("job_done", done, 1);
    endtask

    task automatic check_c();
        longint s;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                s = 0;
                for (int k = 0; k < SIZE; k++) s += longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
                check($sformatf("c[%0d][%0d]", i, j), acc[i][j], s);
            end
        end
    endtask

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = 0;
                mat_b[i][j] = 0;
            end
        end
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Identity A: C equals B.
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = (i == j) ? 1 : 0;
                mat_b[i][j] = 4 * i + j + 1;
            end
        end
        base = clr_cnt;
        run_job();
        check_c();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) check("ident", acc[i][j], 4 * i + j + 1);
        check("clr_once_1", clr_cnt - base, 1);
        repeat (3) tick();
        check("rv_hold", result_valid, 1);

        // Full-scale operands.
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = 255;
                mat_b[i][j] = 255;
            end
        run_job();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) check("sat", acc[i][j], 260100);
        tick();

        // Skew pattern on lane 3.
        for (int i = 0; i < SIZE; i++)
            for (int k = 0; k < SIZE; k++) begin
                mat_a[i][k] = 16 * i + k + 1;
                mat_b[k][i] = 16 * i + k + 1;
            end
        skew_tag = 1'b1;
        run_job();
        skew_tag = 1'b0;
        check_c();
        tick();
        tick();

        // Start pulses at cycles 0, 5, 14: one job, re-accept at 15.
        base  = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy1", busy, 1);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy6", busy, 1);
        repeat (8) tick();
        check("ign_done14", done, 1);
        start = 1'b1;
        tick();
        check("ign_idle15", busy, 0);
        check("ign_one_done", done_cnt - base, 1);
        tick();
        start = 1'b0;
        check("reaccept_busy", busy, 1);
        check("reaccept_clr", arr_reset, 1);
        begin
            int n = 0;
            while (!done && n < 60) begin
                tick();
                n++;
            end
        end
        check("reaccept_done", done, 1);
        check_c();
        tick();

        // Reset in the middle of FEED, then a clean job.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_arr_reset", arr_reset, 1);
        tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_a_in", a_in, 0);
        check("rst_b_in", b_in, 0);
        check("rst_rv", result_valid, 0);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = (3 * i + 5 * j + 2) % 256;
                mat_b[i][j] = (7 * i + 2 * j + 1) % 256;
            end
        run_job();
        check_c();

        // Back-to-back: second start raised in DONE, taken on the following IDLE cycle.
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = (11 * i + 13 * j + 7) % 256;
                mat_b[i][j] = (200 + 9 * i + 3 * j) % 256;
            end
        base = clr_cnt;
        run_job();
        check_c();
        check("clr_once_2", clr_cnt - base, 1);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = (i + 2 * j) % 256;
                mat_b[i][j] = (250 - 4 * i - j) % 256;
            end
        base = clr_cnt;
        run_job();
        check_c();
        check("clr_once_3", clr_cnt - base, 1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
